// File: rtl/regfile_scb.sv
// Dual-read, single-write register file with a per-entry busy scoreboard for hazard tracking.
// Reads, bypass and busy status are combinational; writes and scoreboard updates take effect on the next posedge; no backpressure.
module regfile_scb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CW-1:0]    busy_cnt_q;
    logic [CW-1:0]    busy_cnt_d;

    logic wr_ok;
    logic iss_ok;
    logic set_new;
    logic clr_eff;
    logic ra1_zero;
    logic ra2_zero;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        wr_ok    = we && !is_zero_reg(wa);
        iss_ok   = iss_en && !is_zero_reg(iss_addr);
        ra1_zero = is_zero_reg(ra1);
        ra2_zero = is_zero_reg(ra2);
    end

    // Set has priority over clear on the same entry, so a clear only counts
    // when it really drops a bit that no issue re-asserts this cycle.
    always_comb begin
        set_new    = iss_ok && !busy_q[iss_addr];
        clr_eff    = wr_ok && busy_q[wa] && !(iss_ok && (iss_addr == wa));
        busy_d     = busy_q;
        if (wr_ok) begin
            busy_d[wa] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_cnt_d = busy_cnt_q + CW'(set_new) - CW'(clr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Write-through bypass; outputs are forced quiet while reset is held.
    always_comb begin
        rd1 = '0;
        if (rst_n && !ra1_zero) begin
            if (we && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = mem_q[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (rst_n && !ra2_zero) begin
            if (we && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = mem_q[ra2];
            end
        end
    end

    always_comb begin
        busy1 = rst_n && !ra1_zero && busy_q[ra1] && !(we && (wa == ra1));
        busy2 = rst_n && !ra2_zero && busy_q[ra2] && !(we && (wa == ra2));
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scb.sv
module tb_regfile_scb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, iss_addr;
    logic [31:0] rd1, rd2, wd;
    logic        we, iss_en, busy1, busy2;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_scb #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        we = v.we; wa = v.wa; wd = v.wd;
        iss_en = v.iss; iss_addr = v.ia;
        ra1 = v.ra1; ra2 = v.ra2;
    endtask

    // Inputs change after negedge; combinational outputs are checked before the
    // posedge, the registered count just after it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        chk({tag, " rd1"}, rd1, v.e_rd1);
        chk({tag, " rd2"}, rd2, v.e_rd2);
        chk({tag, " busy1"}, {31'd0, busy1}, {31'd0, v.e_b1});
        chk({tag, " busy2"}, {31'd0, busy2}, {31'd0, v.e_b2});
        @(posedge clk);
        #1;
        chk({tag, " busy_cnt"}, {26'd0, busy_cnt}, {26'd0, v.e_cnt});
    endtask

    vec_t vt[18];
    vec_t idle;

    initial begin
        //        we  wa     wd             iss ia     ra1    ra2    rd1            rd2            b1 b2 cnt
        vt[0]  = '{1, 5'd3,  32'hDEADBEEF,  0, 5'd0,  5'd3,  5'd0,  32'hDEADBEEF,  32'h0,         0, 0, 6'd0};
        vt[1]  = '{0, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd0,  32'hDEADBEEF,  32'h0,         0, 0, 6'd0};
        vt[2]  = '{1, 5'd7,  32'h11,        0, 5'd0,  5'd7,  5'd3,  32'h11,        32'hDEADBEEF,  0, 0, 6'd0};
        vt[3]  = '{1, 5'd7,  32'h22,        0, 5'd0,  5'd7,  5'd7,  32'h22,        32'h22,        0, 0, 6'd0};
        vt[4]  = '{0, 5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd3,  32'h22,        32'hDEADBEEF,  0, 0, 6'd0};
        vt[5]  = '{1, 5'd0,  32'hFFFFFFFF,  0, 5'd0,  5'd0,  5'd7,  32'h0,         32'h22,        0, 0, 6'd0};
        vt[6]  = '{0, 5'd0,  32'h0,         1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         0, 0, 6'd0};
        vt[7]  = '{0, 5'd0,  32'h0,         1, 5'd5,  5'd5,  5'd0,  32'h0,         32'h0,         0, 0, 6'd1};
        vt[8]  = '{0, 5'd0,  32'h0,         1, 5'd9,  5'd5,  5'd9,  32'h0,         32'h0,         1, 0, 6'd2};
        vt[9]  = '{1, 5'd5,  32'h55,        0, 5'd0,  5'd5,  5'd9,  32'h55,        32'h0,         0, 1, 6'd1};
        vt[10] = '{0, 5'd0,  32'h0,         1, 5'd4,  5'd4,  5'd9,  32'h0,         32'h0,         0, 1, 6'd2};
        vt[11] = '{1, 5'd4,  32'h44,        1, 5'd4,  5'd4,  5'd9,  32'h44,        32'h0,         0, 1, 6'd2};
        vt[12] = '{0, 5'd0,  32'h0,         0, 5'd0,  5'd4,  5'd5,  32'h44,        32'h55,        1, 0, 6'd2};
        vt[13] = '{1, 5'd6,  32'h66,        1, 5'd6,  5'd6,  5'd4,  32'h66,        32'h44,        0, 1, 6'd3};
        vt[14] = '{1, 5'd9,  32'h99,        1, 5'd10, 5'd6,  5'd9,  32'h66,        32'h99,        1, 0, 6'd3};
        vt[15] = '{0, 5'd0,  32'h0,         1, 5'd6,  5'd10, 5'd9,  32'h0,         32'h99,        1, 0, 6'd3};
        vt[16] = '{1, 5'd9,  32'h9A,        0, 5'd0,  5'd6,  5'd9,  32'h66,        32'h9A,        1, 0, 6'd3};
        vt[17] = '{1, 5'd2,  32'hAB,        0, 5'd0,  5'd2,  5'd4,  32'hAB,        32'h44,        0, 1, 6'd3};
        idle   = '{0, 5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         0, 0, 6'd0};

        rst_n = 1'b0;
        drive(idle);
        ra1 = 5'd3; ra2 = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd1", rd1, 32'h0);
        chk("reset rd2", rd2, 32'h0);
        chk("reset busy1", {31'd0, busy1}, 32'd0);
        chk("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(vt[i], $sformatf("v%0d", i));
        end

        // Async reset between edges: busy {4,6,10}, mem[2]=0xAB.
        @(negedge clk);
        drive(idle);
        ra1 = 5'd4; ra2 = 5'd2;
        #1;
        chk("pre-rst busy1", {31'd0, busy1}, 32'd1);
        chk("pre-rst rd2", rd2, 32'hAB);
        rst_n = 1'b0;
        #1;
        chk("arst busy_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("arst busy1", {31'd0, busy1}, 32'd0);
        chk("arst rd2", rd2, 32'h0);
        we = 1'b1; wa = 5'd2; wd = 32'h77; iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        chk("in-rst bypass rd2", rd2, 32'h0);
        @(posedge clk);
        #1;
        chk("in-rst issue ignored", {26'd0, busy_cnt}, 32'd0);
        @(negedge clk);
        drive(idle);
        ra1 = 5'd3; ra2 = 5'd2;
        rst_n = 1'b1;
        #1;
        chk("post-rst rd2", rd2, 32'h0);
        chk("post-rst busy1", {31'd0, busy1}, 32'd0);

        apply('{0, 5'd0, 32'h0, 1, 5'd8, 5'd2, 5'd8, 32'h0, 32'h0, 0, 0, 6'd1}, "first-op");

        // Fill every entry: count saturates at 31 with entry 0 excluded.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(idle);
            iss_en = 1'b1; iss_addr = 5'(a);
        end
        @(negedge clk);
        drive(idle);
        #1;
        chk("full busy_cnt", {26'd0, busy_cnt}, 32'd31);
        apply('{0, 5'd0, 32'h0, 1, 5'd0, 5'd31, 5'd0, 32'h0, 32'h0, 1, 0, 6'd31}, "full-iss0");

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(idle);
            we = 1'b1; wa = 5'(a); wd = 32'(a);
        end
        @(negedge clk);
        drive(idle);
        ra1 = 5'd31; ra2 = 5'd17;
        #1;
        chk("drain busy_cnt", {26'd0, busy_cnt}, 32'd0);
        chk("drain rd1", rd1, 32'd31);
        chk("drain rd2", rd2, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
